// File: rtl/core_trace_buf.sv
// Retirement-trace recorder: captures {pc, inst, ctrl} for each retired instruction,
// stops on EBREAK, an external trigger or a cycle watchdog, then drains oldest-first.
module core_trace_buf #(
  parameter int XLEN      = 32,
  parameter int CTRL_W    = 16,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic                       mode,
  input  logic [31:0]                cyc_limit,
  input  logic                       trig_ext,
  input  logic                       ret_valid,
  input  logic [XLEN-1:0]            ret_pc,
  input  logic [XLEN-1:0]            ret_inst,
  input  logic [CTRL_W-1:0]          ret_ctrl,
  input  logic                       rd_start,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [XLEN-1:0]            rd_pc,
  output logic [XLEN-1:0]            rd_inst,
  output logic [CTRL_W-1:0]          rd_ctrl,
  output logic                       rd_last,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 trig_cause,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 2 * XLEN + CTRL_W;
  localparam int PW = (POST_TRIG < 1) ? 1 : $clog2(POST_TRIG + 1);

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_EBREAK = 2'b01;
  localparam logic [1:0] CAUSE_EXT    = 2'b10;
  localparam logic [1:0] CAUSE_WDOG   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_POST,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t            state_reg, state_next;
  logic              mode_reg, mode_next;
  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [CW-1:0]     remaining_reg, remaining_next;
  logic              overflow_reg, overflow_next;
  logic [1:0]        cause_reg, cause_next;
  logic [31:0]       cyc_cnt_reg, cyc_cnt_next;
  logic [PW-1:0]     post_cnt_reg, post_cnt_next;
  logic              rd_valid_reg, rd_valid_next;

  logic              wr_en;
  logic [EW-1:0]     wr_data;
  logic [AW-1:0]     rd_addr;
  logic [EW-1:0]     rd_data_reg;
  logic [EW-1:0]     rd_entry;

  logic              capturing;
  logic              full;
  logic              is_ebreak;
  logic              wd_hit;
  logic              accept;

  logic [EW-1:0]     mem [DEPTH];

  assign wr_data   = {ret_pc, ret_inst, ret_ctrl};
  assign capturing = (state_reg == S_CAPTURE) || (state_reg == S_POST);
  assign full      = (count_reg == CW'(DEPTH));
  assign is_ebreak = ret_valid && (ret_inst == XLEN'(32'h0010_0073));
  assign wd_hit    = (cyc_limit != 32'd0) && (cyc_cnt_reg == cyc_limit - 32'd1);
  assign accept    = rd_valid_reg && rd_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      mode_reg      <= 1'b0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      remaining_reg <= '0;
      overflow_reg  <= 1'b0;
      cause_reg     <= CAUSE_NONE;
      cyc_cnt_reg   <= '0;
      post_cnt_reg  <= '0;
      rd_valid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      remaining_reg <= remaining_next;
      overflow_reg  <= overflow_next;
      cause_reg     <= cause_next;
      cyc_cnt_reg   <= cyc_cnt_next;
      post_cnt_reg  <= post_cnt_next;
      rd_valid_reg  <= rd_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    remaining_next = remaining_reg;
    overflow_next  = overflow_reg;
    cause_next     = cause_reg;
    cyc_cnt_next   = cyc_cnt_reg;
    post_cnt_next  = post_cnt_reg;
    rd_valid_next  = rd_valid_reg;
    wr_en          = 1'b0;

    // Shared write rule for CAPTURE and POST, including the triggering retirement.
    if (capturing && ret_valid) begin
      if (!full) begin
        wr_en       = 1'b1;
        wr_ptr_next = wr_ptr_reg + AW'(1);
        count_next  = count_reg + CW'(1);
      end else begin
        overflow_next = 1'b1;
        if (mode_reg) begin
          wr_en       = 1'b1;
          wr_ptr_next = wr_ptr_reg + AW'(1);
        end
      end
    end

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (arm) begin
          state_next    = S_CAPTURE;
          mode_next     = mode;
          count_next    = '0;
          overflow_next = 1'b0;
          cause_next    = CAUSE_NONE;
          wr_ptr_next   = '0;
          cyc_cnt_next  = '0;
        end else if (state_reg == S_DONE && rd_start) begin
          if (count_reg == '0) begin
            state_next = S_IDLE;
          end else begin
            state_next     = S_DRAIN;
            rd_ptr_next    = (mode_reg && overflow_reg) ? wr_ptr_reg : '0;
            remaining_next = count_reg;
            rd_valid_next  = 1'b1;
          end
        end
      end

      S_CAPTURE: begin
        if (cyc_cnt_reg != '1) begin
          cyc_cnt_next = cyc_cnt_reg + 32'd1;
        end
        if (is_ebreak || trig_ext || wd_hit) begin
          if (is_ebreak) begin
            cause_next = CAUSE_EBREAK;
          end else if (trig_ext) begin
            cause_next = CAUSE_EXT;
          end else begin
            cause_next = CAUSE_WDOG;
          end
          if (POST_TRIG == 0) begin
            state_next = S_DONE;
          end else begin
            state_next    = S_POST;
            post_cnt_next = PW'(POST_TRIG);
          end
        end
      end

      S_POST: begin
        if (ret_valid) begin
          post_cnt_next = post_cnt_reg - PW'(1);
          if (post_cnt_reg == PW'(1)) begin
            state_next = S_DONE;
          end
        end
      end

      S_DRAIN: begin
        if (accept) begin
          rd_ptr_next    = rd_ptr_reg + AW'(1);
          remaining_next = remaining_reg - CW'(1);
          if (remaining_reg == CW'(1)) begin
            rd_valid_next = 1'b0;
            count_next    = '0;
            state_next    = S_IDLE;
          end
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Read address tracks the pointer after this cycle's update so the data
    // register always holds entry[rd_ptr_reg].
    rd_addr = rd_ptr_next;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= wr_data;
    end
    rd_data_reg <= mem[rd_addr];
  end

  // Gate the readout so no stale or partial entry is visible while rd_valid is low.
  genvar gi;
  generate
    for (gi = 0; gi < EW; gi++) begin : g_rd_gate
      assign rd_entry[gi] = rd_data_reg[gi] & rd_valid_reg;
    end
  endgenerate

  assign rd_pc      = rd_entry[EW-1 -: XLEN];
  assign rd_inst    = rd_entry[CTRL_W +: XLEN];
  assign rd_ctrl    = rd_entry[CTRL_W-1:0];
  assign rd_valid   = rd_valid_reg;
  assign rd_last    = rd_valid_reg && (remaining_reg == CW'(1));
  assign busy       = capturing;
  assign done       = (state_reg == S_DONE);
  assign trig_cause = cause_reg;
  assign count      = count_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_core_trace_buf.sv
// Directed bench for core_trace_buf: three instances (linear, circular+post, deep watchdog)
// share stimulus; each test resets all and checks the instance it targets.
module tb_core_trace_buf;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arm = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] cyc_limit = 32'd0;
  logic        trig_ext = 1'b0;
  logic        ret_valid = 1'b0;
  logic [31:0] ret_pc = 32'd0;
  logic [31:0] ret_inst = 32'd0;
  logic [15:0] ret_ctrl = 16'd0;
  logic        rd_start = 1'b0;
  logic        rd_ready = 1'b0;

  logic        rd_valid_a, rd_last_a, busy_a, done_a, overflow_a;
  logic [31:0] rd_pc_a, rd_inst_a;
  logic [15:0] rd_ctrl_a;
  logic [1:0]  cause_a;
  logic [3:0]  count_a;

  logic        rd_valid_b, rd_last_b, busy_b, done_b, overflow_b;
  logic [31:0] rd_pc_b, rd_inst_b;
  logic [15:0] rd_ctrl_b;
  logic [1:0]  cause_b;
  logic [3:0]  count_b;

  logic        rd_valid_c, rd_last_c, busy_c, done_c, overflow_c;
  logic [31:0] rd_pc_c, rd_inst_c;
  logic [15:0] rd_ctrl_c;
  logic [1:0]  cause_c;
  logic [6:0]  count_c;

  int n_checks = 0;
  int n_errors = 0;
  int sel = 0;

  logic        o_valid, o_last, o_busy, o_done, o_ovf;
  logic [31:0] o_pc, o_inst;
  logic [15:0] o_ctrl;
  logic [1:0]  o_cause;
  logic [7:0]  o_count;

  always #5 clk = ~clk;

  core_trace_buf #(.XLEN(32), .CTRL_W(16), .DEPTH(8), .POST_TRIG(0)) u_a (
    .clk(clk), .rst(rst), .arm(arm), .mode(mode), .cyc_limit(cyc_limit),
    .trig_ext(trig_ext), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst),
    .ret_ctrl(ret_ctrl), .rd_start(rd_start), .rd_valid(rd_valid_a), .rd_ready(rd_ready),
    .rd_pc(rd_pc_a), .rd_inst(rd_inst_a), .rd_ctrl(rd_ctrl_a), .rd_last(rd_last_a),
    .busy(busy_a), .done(done_a), .trig_cause(cause_a), .count(count_a), .overflow(overflow_a)
  );

  core_trace_buf #(.XLEN(32), .CTRL_W(16), .DEPTH(8), .POST_TRIG(2)) u_b (
    .clk(clk), .rst(rst), .arm(arm), .mode(mode), .cyc_limit(cyc_limit),
    .trig_ext(trig_ext), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst),
    .ret_ctrl(ret_ctrl), .rd_start(rd_start), .rd_valid(rd_valid_b), .rd_ready(rd_ready),
    .rd_pc(rd_pc_b), .rd_inst(rd_inst_b), .rd_ctrl(rd_ctrl_b), .rd_last(rd_last_b),
    .busy(busy_b), .done(done_b), .trig_cause(cause_b), .count(count_b), .overflow(overflow_b)
  );

  core_trace_buf #(.XLEN(32), .CTRL_W(16), .DEPTH(64), .POST_TRIG(0)) u_c (
    .clk(clk), .rst(rst), .arm(arm), .mode(mode), .cyc_limit(cyc_limit),
    .trig_ext(trig_ext), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_inst(ret_inst),
    .ret_ctrl(ret_ctrl), .rd_start(rd_start), .rd_valid(rd_valid_c), .rd_ready(rd_ready),
    .rd_pc(rd_pc_c), .rd_inst(rd_inst_c), .rd_ctrl(rd_ctrl_c), .rd_last(rd_last_c),
    .busy(busy_c), .done(done_c), .trig_cause(cause_c), .count(count_c), .overflow(overflow_c)
  );

  always_comb begin
    o_valid = rd_valid_a; o_last = rd_last_a; o_busy = busy_a; o_done = done_a;
    o_ovf = overflow_a; o_pc = rd_pc_a; o_inst = rd_inst_a; o_ctrl = rd_ctrl_a;
    o_cause = cause_a; o_count = {4'd0, count_a};
    if (sel == 1) begin
      o_valid = rd_valid_b; o_last = rd_last_b; o_busy = busy_b; o_done = done_b;
      o_ovf = overflow_b; o_pc = rd_pc_b; o_inst = rd_inst_b; o_ctrl = rd_ctrl_b;
      o_cause = cause_b; o_count = {4'd0, count_b};
    end else if (sel == 2) begin
      o_valid = rd_valid_c; o_last = rd_last_c; o_busy = busy_c; o_done = done_c;
      o_ovf = overflow_c; o_pc = rd_pc_c; o_inst = rd_inst_c; o_ctrl = rd_ctrl_c;
      o_cause = cause_c; o_count = {1'b0, count_c};
    end
  end

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[23:0], 8'h13};
  endfunction

  function automatic logic [15:0] ctrl_of(input logic [31:0] pc);
    return pc[15:0] ^ 16'hA5A5;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; arm = 1'b0; trig_ext = 1'b0; ret_valid = 1'b0;
    rd_start = 1'b0; rd_ready = 1'b0; cyc_limit = 32'd0; mode = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] inst);
    ret_valid = 1'b1; ret_pc = pc; ret_inst = inst; ret_ctrl = ctrl_of(pc);
    @(negedge clk);
    ret_valid = 1'b0;
  endtask

  // n plain retirements at base+4k followed by an EBREAK at base+4n.
  task automatic cap_seq(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) retire(base + 32'(4 * k), inst_of(base + 32'(4 * k)));
    retire(base + 32'(4 * n), EBREAK);
  endtask

  task automatic drain(input string name, input int n, input logic [31:0] base,
                       input bit toggle, input bit last_ebreak);
    int k;
    int cyc;
    bit held;
    logic [31:0] h_pc, h_inst, exp_pc, exp_inst;
    logic [15:0] h_ctrl;
    k = 0; cyc = 0; held = 1'b0;
    h_pc = '0; h_inst = '0; h_ctrl = '0;
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    while (k < n && cyc < 400) begin
      rd_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (held) begin
        check({name, "_stall_pc"}, 64'(o_pc), 64'(h_pc));
        check({name, "_stall_inst"}, 64'(o_inst), 64'(h_inst));
        check({name, "_stall_ctrl"}, 64'(o_ctrl), 64'(h_ctrl));
      end
      if (o_valid) begin
        check({name, "_last"}, 64'(o_last), 64'(k == n - 1));
        if (rd_ready) begin
          exp_pc   = base + 32'(4 * k);
          exp_inst = (last_ebreak && k == n - 1) ? EBREAK : inst_of(exp_pc);
          check({name, "_pc"}, 64'(o_pc), 64'(exp_pc));
          check({name, "_inst"}, 64'(o_inst), 64'(exp_inst));
          check({name, "_ctrl"}, 64'(o_ctrl), 64'(ctrl_of(exp_pc)));
          $display("%s entry %0d pc=%08h inst=%08h last=%0b", name, k, o_pc, o_inst, o_last);
          k++;
        end
      end
      held = o_valid && !rd_ready;
      h_pc = o_pc; h_inst = o_inst; h_ctrl = o_ctrl;
      @(negedge clk);
      cyc++;
    end
    rd_ready = 1'b0;
    check({name, "_accepted"}, 64'(k), 64'(n));
    check({name, "_end_valid"}, 64'(o_valid), 64'd0);
    check({name, "_end_done"}, 64'(o_done), 64'd0);
    check({name, "_end_count"}, 64'(o_count), 64'd0);
  endtask

  initial begin
    int k;
    int cyc;
    bit saw_valid;

    // Reset state
    sel = 0;
    do_reset();
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_cause", 64'(o_cause), 64'd0);
    check("rst_ovf", 64'(o_ovf), 64'd0);
    check("rst_last", 64'(o_last), 64'd0);

    // Linear EBREAK stop
    sel = 0;
    do_reset();
    pulse_arm();
    check("lin_busy", 64'(o_busy), 64'd1);
    cap_seq(32'h0, 5);
    check("lin_cause", 64'(o_cause), 64'd1);
    check("lin_count", 64'(o_count), 64'd6);
    check("lin_ovf", 64'(o_ovf), 64'd0);
    check("lin_done", 64'(o_done), 64'd1);
    check("lin_busy_off", 64'(o_busy), 64'd0);
    drain("lin", 6, 32'h0, 1'b0, 1'b1);

    // Circular with post-trigger window
    sel = 1;
    do_reset();
    mode = 1'b1;
    pulse_arm();
    for (int i = 0; i < 20; i++) begin
      ret_valid = 1'b1; ret_pc = 32'(4 * i); ret_inst = inst_of(32'(4 * i));
      ret_ctrl = ctrl_of(32'(4 * i)); trig_ext = (i == 15);
      @(negedge clk);
      if (i == 15) begin
        check("circ_post_busy", 64'(o_busy), 64'd1);
        check("circ_post_done", 64'(o_done), 64'd0);
      end
    end
    ret_valid = 1'b0; trig_ext = 1'b0;
    check("circ_done", 64'(o_done), 64'd1);
    check("circ_count", 64'(o_count), 64'd8);
    check("circ_ovf", 64'(o_ovf), 64'd1);
    check("circ_cause", 64'(o_cause), 64'd2);
    drain("circ", 8, 32'h28, 1'b0, 1'b0);

    // Watchdog on the deep instance
    sel = 2;
    do_reset();
    cyc_limit = 32'd100;
    pulse_arm();
    for (int i = 0; i < 100; i++) begin
      retire(32'(4 * i), inst_of(32'(4 * i)));
      if (i == 98) check("wd_not_yet", 64'(o_done), 64'd0);
    end
    cyc_limit = 32'd0;
    check("wd_done", 64'(o_done), 64'd1);
    check("wd_cause", 64'(o_cause), 64'd3);
    check("wd_count", 64'(o_count), 64'd64);
    check("wd_ovf", 64'(o_ovf), 64'd1);
    drain("wd", 64, 32'h0, 1'b0, 1'b0);

    // Backpressure drain
    sel = 0;
    do_reset();
    pulse_arm();
    cap_seq(32'h200, 5);
    check("bp_count", 64'(o_count), 64'd6);
    drain("bp", 6, 32'h200, 1'b1, 1'b1);

    // EBREAK and external trigger together
    do_reset();
    pulse_arm();
    trig_ext = 1'b1;
    retire(32'h40, EBREAK);
    trig_ext = 1'b0;
    check("prio_cause", 64'(o_cause), 64'd1);
    check("prio_count", 64'(o_count), 64'd1);

    // External trigger without a retirement
    do_reset();
    pulse_arm();
    retire(32'h0, inst_of(32'h0));
    retire(32'h4, inst_of(32'h4));
    trig_ext = 1'b1;
    @(negedge clk);
    trig_ext = 1'b0;
    check("ext_cause", 64'(o_cause), 64'd2);
    check("ext_count", 64'(o_count), 64'd2);
    check("ext_done", 64'(o_done), 64'd1);

    // rd_start with an empty buffer
    do_reset();
    pulse_arm();
    trig_ext = 1'b1;
    @(negedge clk);
    trig_ext = 1'b0;
    check("empty_done", 64'(o_done), 64'd1);
    check("empty_count", 64'(o_count), 64'd0);
    rd_start = 1'b1; rd_ready = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      saw_valid = saw_valid | o_valid;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    check("empty_idle_done", 64'(o_done), 64'd0);
    check("empty_idle_busy", 64'(o_busy), 64'd0);
    check("empty_no_valid", 64'(saw_valid), 64'd0);

    // arm during CAPTURE is ignored
    do_reset();
    pulse_arm();
    retire(32'h0, inst_of(32'h0));
    retire(32'h4, inst_of(32'h4));
    pulse_arm();
    cap_seq(32'h8, 1);
    check("rearm_count", 64'(o_count), 64'd4);
    check("rearm_cause", 64'(o_cause), 64'd1);

    // Reset in the middle of a drain
    do_reset();
    pulse_arm();
    cap_seq(32'h0, 5);
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    k = 0; cyc = 0;
    rd_ready = 1'b1;
    while (k < 3 && cyc < 20) begin
      if (o_valid) k++;
      if (k == 3) rd_ready = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("mid_accepted", 64'(k), 64'd3);
    check("mid_valid_before", 64'(o_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(o_valid), 64'd0);
    check("mid_rst_done", 64'(o_done), 64'd0);
    check("mid_rst_count", 64'(o_count), 64'd0);
    check("mid_rst_busy", 64'(o_busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_idle_done", 64'(o_done), 64'd0);
    pulse_arm();
    cap_seq(32'h100, 2);
    check("mid_new_count", 64'(o_count), 64'd3);
    check("mid_new_done", 64'(o_done), 64'd1);
    drain("post_rst", 3, 32'h100, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/core_trace_buf.md
Name: core_trace_buf

Overview:
- Synthesizable retirement-trace recorder attached to the RISC-V core's retire point. Captures PC, instruction and packed control signals per retired instruction into an on-chip buffer of DEPTH entries.
- Stops on EBREAK, an external trigger, or a cycle watchdog; supports a post-trigger window.
- After stopping, streams entries out oldest-first over a valid/ready port to a debug or host reader.

Parameters:
- XLEN, 32, width of PC and instruction fields.
- CTRL_W, 16, width of packed control-signal vector per entry.
- DEPTH, 64, number of trace entries; power of two, at least 2.
- POST_TRIG, 8, retirements recorded after the trigger before stopping; 0 means stop at once.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- arm  in  1  pulse: clear the buffer and start capture.
- mode  in  1  0 = linear (keep the first DEPTH entries), 1 = circular (keep the last DEPTH entries).
- cyc_limit  in  32  watchdog cycle limit; 0 disables the watchdog.
- trig_ext  in  1  external trigger.
- ret_valid  in  1  one instruction retires this cycle.
- ret_pc  in  XLEN  PC of the retiring instruction.
- ret_inst  in  XLEN  retiring instruction word.
- ret_ctrl  in  CTRL_W  control signals of the retiring instruction.
- rd_start  in  1  pulse in DONE: begin drain.
- rd_valid  out  1  readout entry valid.
- rd_ready  in  1  reader accepts the entry.
- rd_pc  out  XLEN  readout PC field.
- rd_inst  out  XLEN  readout instruction field.
- rd_ctrl  out  CTRL_W  readout control field.
- rd_last  out  1  current readout entry is the final one.
- busy  out  1  state is CAPTURE or POST.
- done  out  1  state is DONE.
- trig_cause  out  2  00 none, 01 EBREAK, 10 external, 11 watchdog.
- count  out  $clog2(DEPTH+1)  valid entries held.
- overflow  out  1  at least one retirement was dropped (mode 0) or overwritten (mode 1).

Behaviour:
- Reset (rst=0, asynchronous):
  - State returns to IDLE.
  - All outputs, wr_ptr, rd_ptr, cycle counter and post counter are set to 0.
  - Storage contents become don't-care.
- States are IDLE, CAPTURE, POST, DONE, DRAIN.
- Arming:
  - arm in IDLE or DONE clears count, overflow, trig_cause, wr_ptr and cyc_cnt, latches mode, then goes to CAPTURE next cycle.
  - arm in CAPTURE, POST or DRAIN is ignored.
- CAPTURE write rule:
  - On ret_valid=1 the entry {ret_pc, ret_inst, ret_ctrl} is written at wr_ptr, and wr_ptr increments modulo DEPTH.
  - The write is visible in count on the next cycle.
- count saturates at DEPTH:
  - Mode 0 with count==DEPTH: writes are dropped and overflow is set to 1.
  - Mode 1 with count==DEPTH: the oldest entry is overwritten and overflow is set to 1.
- cyc_cnt increments every cycle in CAPTURE, saturating at 2^32-1.
- Trigger conditions, evaluated every CAPTURE cycle:
  - EBREAK: ret_valid && ret_inst==32'h00100073.
  - External: trig_ext=1.
  - Watchdog: cyc_limit!=0 && cyc_cnt==cyc_limit-1.
  - Priority when several fire together: EBREAK > external > watchdog.
  - The retirement in the triggering cycle, including the EBREAK itself, is recorded under the normal write rule.
- On trigger:
  - trig_cause is latched.
  - If POST_TRIG==0, go to DONE; otherwise load post_cnt=POST_TRIG and go to POST.
- POST:
  - Each ret_valid retirement is written under the normal write rule and decrements post_cnt.
  - When post_cnt reaches 0, go to DONE.
  - Further triggers are ignored and cyc_cnt is frozen.
- DONE:
  - done=1; contents and count are held.
  - rd_start goes to DRAIN with rd_ptr = (mode1 && overflow) ? wr_ptr : 0.
  - If count==0, rd_start goes directly to IDLE.
- DRAIN:
  - rd_valid is registered and asserted the cycle after entry.
  - rd_pc, rd_inst and rd_ctrl reflect entry[rd_ptr] and must stay stable while rd_valid && !rd_ready.
  - On rd_valid && rd_ready: rd_ptr increments modulo DEPTH and remaining decrements.
  - rd_last = rd_valid && remaining==1.
  - When the last entry is accepted, rd_valid goes to 0, done goes to 0 and the state returns to IDLE; count clears to 0.
- ret_valid and trig_ext are ignored outside CAPTURE and POST.
- rd_start is ignored outside DONE.
- rst asserted mid-operation, including mid-drain, clears rd_valid, done and busy immediately; no partial entry is ever presented.

Test Plan:
- Linear EBREAK stop (DEPTH=8, POST_TRIG=0, mode 0): arm, then retire PC 0,4,8,0xC,0x10 plus EBREAK at 0x14 -> trig_cause=01, count=6, overflow=0, done=1; drain yields PCs 0..0x14 in order, rd_last on inst 00100073.
- Circular with post-trigger (DEPTH=8, POST_TRIG=2, mode 1): retire PC=4*i for i=0..19, trig_ext pulsed at i=15 -> stops after i=17; count=8, overflow=1, cause=10; drain yields PCs 0x28..0x44 in order.
- Watchdog (DEPTH=64, POST_TRIG=0, mode 0, cyc_limit=100): ret_valid=1 every cycle, no EBREAK -> DONE after 100 CAPTURE cycles, cause=11, count=64, overflow=1; drain yields the first 64 PCs.
- Backpressure: drain 6 entries with rd_ready toggling 1,0,1,0 -> each entry is accepted exactly once, fields are stable across stall cycles, rd_last only on the 6th, and IDLE follows the final accept.
- Priority and edge cases:
  - EBREAK and trig_ext in the same cycle -> cause=01.
  - trig_ext with ret_valid=0 -> cause=10 and count unchanged.
  - rd_start with count==0 -> IDLE and rd_valid never rises.
  - arm during CAPTURE -> ignored.
- Reset mid-drain: assert rst low after 3 of 6 entries are accepted -> rd_valid, done, count and busy are 0 asynchronously; after release the state is IDLE and a new arm captures normally.
